// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: FSM state encoding and occupancy width.
package skid_buffer_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Number of words held in each state; illegal encodings report as empty.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// Upstream/downstream valid-ready handshake plus occupancy status for the skid buffer.
interface skid_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  import skid_buffer_pkg::*;

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [OCC_W-1:0]      occ;

  // master: the environment that feeds words in and drains them out
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, occ
  );

  // slave: the buffer itself
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, occ
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer, 1-cycle latency, full throughput, all outputs registered.
// s_ready is a flop and never looks at m_ready combinationally; a stalled word holds steady.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  skid_buffer_if.slave bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic [OCC_W-1:0]      occ_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.s_valid & s_ready_q;
  assign out_xfer = m_valid_q & bus.m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = bus.s_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && !out_xfer) begin
          skid_d  = bus.s_data;
          state_d = FULL;
        end else if (in_xfer && out_xfer) begin
          main_d = bus.s_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // upstream is already stalled here, so only the drain side matters
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are pure flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d == BUSY) || (state_d == FULL);
      occ_q     <= occ_of(state_d);
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_data  = main_q;
  assign bus.m_valid = m_valid_q;
  assign bus.occ     = occ_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and randomized checks of skid_buffer against hand-computed values and a queue model.
module tb_skid_buffer;
  import skid_buffer_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  skid_buffer_if #(.DATA_WIDTH(DW)) bus ();

  skid_buffer #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            do_in;
    bit            do_out;
    logic [DW-1:0] wdata;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rst         = 1'b1;

    // reset held for 5 edges, with a handshake attempt that must be ignored
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    repeat (5) begin
      step();
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_occ",     32'(bus.occ),     32'd0);
    end
    bus.s_valid = 1'b0;
    rst = 1'b0;
    step();
    check("release_s_ready", 32'(bus.s_ready), 32'd1);
    check("release_m_valid", 32'(bus.m_valid), 32'd0);
    check("release_occ",     32'(bus.occ),     32'd0);

    // pass-through at full rate
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(i);
      step();
      check("pt_m_valid", 32'(bus.m_valid), 32'd1);
      check("pt_m_data",  32'(bus.m_data),  32'(i));
      check("pt_occ",     32'(bus.occ),     32'd1);
      check("pt_s_ready", 32'(bus.s_ready), 32'd1);
    end
    bus.s_valid = 1'b0;
    step();
    check("pt_drain_m_valid", 32'(bus.m_valid), 32'd0);
    check("pt_drain_occ",     32'(bus.occ),     32'd0);

    // backpressure fill
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hAAAA;
    step();
    check("bp1_occ",    32'(bus.occ),    32'd1);
    check("bp1_m_data", 32'(bus.m_data), 32'hAAAA);
    bus.s_data = 16'hBBBB;
    step();
    check("bp2_occ",     32'(bus.occ),     32'd2);
    check("bp2_s_ready", 32'(bus.s_ready), 32'd0);
    check("bp2_m_data",  32'(bus.m_data),  32'hAAAA);
    bus.s_data = 16'hCCCC;
    repeat (2) begin
      step();
      check("bp_hold_occ",     32'(bus.occ),     32'd2);
      check("bp_hold_s_ready", 32'(bus.s_ready), 32'd0);
      check("bp_hold_m_valid", 32'(bus.m_valid), 32'd1);
      check("bp_hold_m_data",  32'(bus.m_data),  32'hAAAA);
    end
    bus.m_ready = 1'b1;
    step();
    check("bp_out2_m_data",  32'(bus.m_data),  32'hBBBB);
    check("bp_out2_occ",     32'(bus.occ),     32'd1);
    check("bp_out2_s_ready", 32'(bus.s_ready), 32'd1);
    step();
    check("bp_out3_m_data", 32'(bus.m_data), 32'hCCCC);
    check("bp_out3_occ",    32'(bus.occ),    32'd1);
    bus.s_valid = 1'b0;
    step();
    check("bp_empty_m_valid", 32'(bus.m_valid), 32'd0);
    check("bp_empty_occ",     32'(bus.occ),     32'd0);

    // simultaneous in/out while BUSY
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    step();
    check("sim_pre_m_data", 32'(bus.m_data), 32'h1234);
    check("sim_pre_occ",    32'(bus.occ),    32'd1);
    bus.m_ready = 1'b1;
    bus.s_data  = 16'h5678;
    step();
    check("sim_m_data",  32'(bus.m_data),  32'h5678);
    check("sim_occ",     32'(bus.occ),     32'd1);
    check("sim_m_valid", 32'(bus.m_valid), 32'd1);
    bus.s_valid = 1'b0;
    step();
    check("sim_empty_occ", 32'(bus.occ), 32'd0);

    // reset while FULL discards both words
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0F0F;
    step();
    bus.s_data = 16'hF0F0;
    step();
    check("mr_full_occ", 32'(bus.occ), 32'd2);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    step();
    check("mr_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mr_rst_occ",     32'(bus.occ),     32'd0);
    check("mr_rst_s_ready", 32'(bus.s_ready), 32'd0);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) begin
      step();
      check("mr_after_m_valid", 32'(bus.m_valid), 32'd0);
      check("mr_after_occ",     32'(bus.occ),     32'd0);
    end
    check("mr_after_s_ready", 32'(bus.s_ready), 32'd1);

    // random stress against a queue model; s_ready is modelled as "fewer than 2 held"
    for (int c = 0; c < 1000; c++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      wdata       = 16'($urandom);
      bus.s_data  = wdata;
      do_in  = bus.s_valid && (sb.size() < 2);
      do_out = bus.m_ready && (sb.size() > 0);
      step();
      if (do_out) void'(sb.pop_front());
      if (do_in) sb.push_back(wdata);
      check("rnd_occ",     32'(bus.occ),     32'(sb.size()));
      check("rnd_m_valid", 32'(bus.m_valid), 32'(sb.size() > 0));
      check("rnd_s_ready", 32'(bus.s_ready), 32'(sb.size() < 2));
      if (sb.size() > 0) check("rnd_m_data", 32'(bus.m_data), 32'(sb[0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
